// File: rtl/mem_responder.sv
// mem_responder: single-port word memory serving fetch/load/store requests
//   with a fixed number of wait states and a req/ready handshake.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the accepting edge.
// Backpressure: req is only sampled in IDLE; busy is high while an access
//   is in flight, and requests arriving then are ignored (never queued).
// Ports: clk/rst (async active-low), req/we/addr/wdata request inputs,
//   ready/rdata/err response outputs, busy status.
// Optional: define MEM_RESP_BYTE_STROBE_EN to add a 4-bit byte-enable
//   input 'be' that masks writes per byte.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_RESP_BYTE_STROBE_EN
  input  logic [3:0]  be,
`endif
  output logic        ready,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef MEM_RESP_BYTE_STROBE_EN
  logic [3:0]  be_q, be_d;
`endif
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             acc_err;
  logic [31:0]      old_word;
  logic [31:0]      wmask;
  logic [31:0]      new_word;
  logic             do_write;

  // Decode of the latched request; only meaningful in RESP.
  always_comb begin
    word_idx = {2'b00, addr_q[31:2]};
    mem_idx  = addr_q[IDX_W+1:2];
    acc_err  = (addr_q[1:0] != 2'b00) || (word_idx >= DEPTH_WORDS);
    // Out-of-range reads are never returned, so the aliased index is harmless.
    old_word = mem[mem_idx];
`ifdef MEM_RESP_BYTE_STROBE_EN
    wmask    = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
`else
    wmask    = 32'hFFFF_FFFF;
`endif
    new_word = (old_word & ~wmask) | (wdata_q & wmask);
    // state_q is async-reset, so a reset during RESP also kills the write.
    do_write = (state_q == S_RESP) && we_q && !acc_err;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MEM_RESP_BYTE_STROBE_EN
    be_d    = be_q;
`endif
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
`ifdef MEM_RESP_BYTE_STROBE_EN
          be_d    = be;
`endif
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // Response registers load on the edge leaving RESP; the memory is
        // written on that same edge, so rdata carries the pre-write word.
        state_d = S_IDLE;
        ready_d = 1'b1;
        err_d   = acc_err;
        rdata_d = acc_err ? 32'h0 : old_word;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
`ifdef MEM_RESP_BYTE_STROBE_EN
      be_q    <= 4'h0;
`endif
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MEM_RESP_BYTE_STROBE_EN
      be_q    <= be_d;
`endif
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[mem_idx] <= new_word;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's unified instruction/data memory port: it serves the fetch, load and store requests that the control FSM issues.
- Single-port word memory with a configurable number of wait states and a request/ready handshake, so the core can stall on memory latency.
- Flags misaligned and out-of-range accesses instead of corrupting memory.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored.
- WAIT_CYCLES, 2, wait states between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = write (store), 0 = read (fetch/load); sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  store data; sampled with req.
- ready  output  1  one-cycle pulse; the access is complete.
- rdata  output  32  read data; valid while ready=1 and held until the next response.
- busy  output  1  high from the cycle after acceptance through the RESP cycle.
- err  output  1  valid with ready; access was misaligned or out of range.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ready=0, busy=0, err=0, rdata=0; wait counter=0.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req=1, latch we/addr/wdata. If WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES-1; otherwise go directly to RESP.
  - WAIT: decrement the counter each cycle; when the counter is 0, go to RESP.
  - RESP: ready=1 for exactly one cycle, then return to IDLE.
- Latency: ready asserts WAIT_CYCLES+1 cycles after the accepting edge (1 cycle when WAIT_CYCLES=0).
- Back-to-back: req is ignored in WAIT and RESP. A new request is accepted at the earliest on the IDLE cycle after RESP, so there is no ready-to-req combinational path.
- Address decode: word index = latched addr[31:2].
  - err = (addr[1:0] != 0) or (index >= DEPTH_WORDS).
- Read: in RESP, rdata = mem[index], or 0 when err=1. rdata holds its value after RESP.
- Write:
  - The memory is updated on the RESP edge only, and only when err=0.
  - rdata on a write response returns the old word (read-before-write), or 0 on err.
- The latched request is immune to input changes after acceptance.
- Reset asserted in WAIT or RESP aborts the access: no write and no ready pulse.
- An error does not lock the block; it returns to IDLE normally.

Optional Feature:
- Macro: MEM_RESP_BYTE_STROBE_EN.
- Defined:
  - Adds port be (input, 4 bits), sampled with req.
  - Writes update only the bytes whose be bit is set (be[0] -> bits 7:0 ... be[3] -> bits 31:24).
  - be=0000 on a write completes with ready but changes nothing.
  - be is ignored on reads.
- Undefined: no be port; every write updates the full 32-bit word.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> ready=0, busy=0, err=0, rdata=0. Then req with addr=0x0 -> ready exactly 3 cycles after acceptance (WAIT_CYCLES=2).
- Write/read: write 0xDEADBEEF to addr 0x10 -> ready, err=0, rdata=old word. Then read addr 0x10 -> rdata=0xDEADBEEF.
- Misaligned: write 0x12345678 to addr 0x12 -> err=1, rdata=0. A subsequent read of 0x10 still returns 0xDEADBEEF.
- Out of range: read addr 0x1000 with DEPTH_WORDS=1024 -> err=1, rdata=0. Busy stays high through RESP, then the block is back in IDLE.
- Ignored req and latching: hold req=1 continuously and toggle addr during WAIT -> one response per accepted request; responses use only the accepted addresses; accepts are spaced WAIT_CYCLES+2 cycles apart.
- Reset mid-write, then byte strobes:
  - Assert rst during WAIT of a write of 0xFFFFFFFF to 0x20 -> no ready, and a later read of 0x20 returns its prior value.
  - With MEM_RESP_BYTE_STROBE_EN: write 0xAABBCCDD with be=0101 over 0x11111111 -> read returns 0x11BB11DD.
